// File: rtl/arb_m8b_2ch.sv
// Two-channel byte arbiter feeding an 8b->32b packer. Whole 4-byte words are
// granted on slot boundaries set by a free-running 2-bit byte counter.
module arb_m8b_2ch #(
  parameter int BURST = 2
) (
  input  logic       clk_4f,
  input  logic       reset_L,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic [1:0] lane_out,
  output logic       owner_out,
  output logic       word_start
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLOT0 = 2'd1,
    SLOT1 = 2'd2
  } state_t;

  localparam logic [1:0] BURST_MAX = 2'(BURST - 1);

  state_t     state_r;
  state_t     state_s;
  logic [1:0] cnt_r;
  logic [1:0] burst_r;
  logic [1:0] burst_s;
  logic       last_r;
  logic       last_s;
  logic       boundary_s;

  assign boundary_s = (cnt_r == 2'd3);
  assign ack0       = (state_r == SLOT0);
  assign ack1       = (state_r == SLOT1);

  // Free-running byte position within the current word slot.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      cnt_r <= 2'd0;
    end else begin
      cnt_r <= cnt_r + 2'd1;
    end
  end

  // Grant state, burst length and last owner.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_r <= IDLE;
      burst_r <= 2'd0;
      last_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      burst_r <= burst_s;
      last_r  <= last_s;
    end
  end

  // Grant decisions are taken only on the last byte of a slot.
  always_comb begin
    state_s = state_r;
    burst_s = burst_r;
    last_s  = last_r;
    if (boundary_s) begin
      case ({req1, req0})
        2'b00: state_s = IDLE;
        2'b01: state_s = SLOT0;
        2'b10: state_s = SLOT1;
        2'b11: begin
          if ((state_r != IDLE) && (burst_r < BURST_MAX)) begin
            state_s = state_r;
          end else if (last_r) begin
            state_s = SLOT0;
          end else begin
            state_s = SLOT1;
          end
        end
        default: state_s = IDLE;
      endcase

      case (state_s)
        SLOT0:   last_s = 1'b0;
        SLOT1:   last_s = 1'b1;
        default: last_s = last_r;
      endcase

      // Owner change and entry from IDLE both show up as a state change.
      if (state_s == IDLE) begin
        burst_s = burst_r;
      end else if (state_s != state_r) begin
        burst_s = 2'd0;
      end else if (burst_r < BURST_MAX) begin
        burst_s = burst_r + 2'd1;
      end else begin
        burst_s = burst_r;
      end
    end else begin
      state_s = state_r;
      burst_s = burst_r;
      last_s  = last_r;
    end
  end

  // Packer-side outputs, one cycle behind the acks.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      data_out   <= 8'h00;
      valid_out  <= 1'b0;
      lane_out   <= 2'd0;
      owner_out  <= 1'b0;
      word_start <= 1'b0;
    end else begin
      valid_out  <= ack0 | ack1;
      lane_out   <= cnt_r;
      owner_out  <= ack1;
      word_start <= (ack0 | ack1) && (cnt_r == 2'd0);
      if (ack0) begin
        data_out <= data0;
      end else if (ack1) begin
        data_out <= data1;
      end else begin
        data_out <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_arb_m8b_2ch.sv
// Scoreboard bench for arb_m8b_2ch: BURST=2 and BURST=1 instances share stimulus
// and are checked against a word-level reference model.
module tb_arb_m8b_2ch;

  logic       clk_4f = 1'b0;
  logic       reset_L;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic [1:0] ack0_o, ack1_o, valid_o, owner_o, ws_o;
  logic [7:0] dout_o [2];
  logic [1:0] lane_o [2];

  always #5 clk_4f = ~clk_4f;

  arb_m8b_2ch #(.BURST(2)) u_b2 (
    .clk_4f(clk_4f), .reset_L(reset_L), .req0(req0), .data0(data0),
    .req1(req1), .data1(data1), .ack0(ack0_o[0]), .ack1(ack1_o[0]),
    .data_out(dout_o[0]), .valid_out(valid_o[0]), .lane_out(lane_o[0]),
    .owner_out(owner_o[0]), .word_start(ws_o[0]));

  arb_m8b_2ch #(.BURST(1)) u_b1 (
    .clk_4f(clk_4f), .reset_L(reset_L), .req0(req0), .data0(data0),
    .req1(req1), .data1(data1), .ack0(ack0_o[1]), .ack1(ack1_o[1]),
    .data_out(dout_o[1]), .valid_out(valid_o[1]), .lane_out(lane_o[1]),
    .owner_out(owner_o[1]), .word_start(ws_o[1]));

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic [1:0] lane;
    logic       owner;
    logic       ws;
  } exp_t;

  typedef struct packed {
    exp_t i1;
    exp_t i0;
  } pair_t;

  pair_t sb[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: owner per word (-1 idle), words in current run, last owner.
  int m_cnt   [2] = '{0, 0};
  int m_state [2] = '{-1, -1};
  int m_run   [2] = '{0, 0};
  int m_last  [2] = '{1, 1};
  int burst_of[2] = '{2, 1};

  task automatic chk(input string name, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0h expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic drv_wait(input int n);
    repeat (n) begin
      @(negedge clk_4f);
      #2;
    end
  endtask

  initial begin
    pair_t p;
    exp_t  e;
    int    nxt;
    forever begin
      @(posedge clk_4f or negedge reset_L);
      if (!reset_L) begin
        for (int i = 0; i < 2; i++) begin
          m_cnt[i] = 0; m_state[i] = -1; m_run[i] = 0; m_last[i] = 1;
        end
        sb.delete();
      end else begin
        for (int i = 0; i < 2; i++) begin
          e.valid = (m_state[i] != -1);
          e.lane  = 2'(m_cnt[i]);
          e.owner = (m_state[i] == 1);
          e.ws    = e.valid && (m_cnt[i] == 0);
          e.data  = (m_state[i] == 0) ? data0 : (m_state[i] == 1) ? data1 : 8'h00;
          if (i == 0) p.i0 = e; else p.i1 = e;
          if (m_cnt[i] == 3) begin
            if (!req0 && !req1) nxt = -1;
            else if (req0 && req1)
              nxt = (m_state[i] != -1 && m_run[i] < burst_of[i]) ? m_state[i] : 1 - m_last[i];
            else nxt = req0 ? 0 : 1;
            if (nxt != -1) begin
              m_run[i]  = (nxt == m_state[i]) ? m_run[i] + 1 : 1;
              m_last[i] = nxt;
            end
            m_state[i] = nxt;
          end
          m_cnt[i] = (m_cnt[i] + 1) % 4;
        end
        sb.push_back(p);
      end
    end
  end

  // Monitor: compare every presented output cycle against the scoreboard.
  initial begin
    pair_t p;
    exp_t  e;
    forever begin
      @(negedge clk_4f);
      #1;
      for (int i = 0; i < 2; i++)
        chk("ack_excl", i, int'(ack0_o[i] & ack1_o[i]), 0);
      if (!reset_L) begin
        for (int i = 0; i < 2; i++) begin
          chk("rst_data", i, int'(dout_o[i]), 0);
          chk("rst_valid", i, int'(valid_o[i]), 0);
          chk("rst_lane", i, int'(lane_o[i]), 0);
          chk("rst_owner", i, int'(owner_o[i]), 0);
          chk("rst_ws", i, int'(ws_o[i]), 0);
          chk("rst_ack0", i, int'(ack0_o[i]), 0);
          chk("rst_ack1", i, int'(ack1_o[i]), 0);
        end
      end else if (sb.size() > 0) begin
        p = sb.pop_front();
        for (int i = 0; i < 2; i++) begin
          e = (i == 0) ? p.i0 : p.i1;
          chk("data_out", i, int'(dout_o[i]), int'(e.data));
          chk("valid_out", i, int'(valid_o[i]), int'(e.valid));
          chk("lane_out", i, int'(lane_o[i]), int'(e.lane));
          chk("owner_out", i, int'(owner_o[i]), int'(e.owner));
          chk("word_start", i, int'(ws_o[i]), int'(e.ws));
          chk("ack0", i, int'(ack0_o[i]), int'(m_state[i] == 0));
          chk("ack1", i, int'(ack1_o[i]), int'(m_state[i] == 1));
        end
      end
    end
  end

  initial begin
    int seen;
    reset_L = 1'b0;
    req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
    drv_wait(3);

    // Single requester straight out of reset: first grant on the 4th edge.
    reset_L = 1'b1; req0 = 1'b1; data0 = 8'hFF;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk_4f); #1;
      chk("s1_ack0", 0, int'(ack0_o[0]), int'(c >= 4));
    end
    #1; req0 = 1'b0;
    drv_wait(6);

    // Both channels contending continuously.
    req0 = 1'b1; req1 = 1'b1; data0 = 8'hDD; data1 = 8'hAA;
    drv_wait(30);
    req0 = 1'b0; req1 = 1'b0;
    drv_wait(8);

    // req1 drops after the 2nd ack; the word still completes.
    req1 = 1'b1; data1 = 8'h01; seen = 0;
    for (int k = 0; k < 8 && seen == 0; k++) begin
      @(negedge clk_4f); #1;
      if (ack1_o[0]) seen = 1;
    end
    chk("s3_grant", 0, seen, 1);
    @(negedge clk_4f); #2; data1 = 8'h02;
    @(negedge clk_4f); #2; data1 = 8'h03; req1 = 1'b0;
    @(negedge clk_4f); #2; data1 = 8'h04;
    @(negedge clk_4f); #2; data1 = 8'h00;
    drv_wait(6);

    // req0 rising while idle at cnt==1 waits for the slot boundary.
    seen = 0;
    for (int k = 0; k < 8 && seen == 0; k++) begin
      @(negedge clk_4f); #1;
      if (lane_o[0] == 2'd0) seen = 1;
    end
    chk("s4_align", 0, seen, 1);
    #1; req0 = 1'b1; data0 = 8'h3C;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk_4f); #1;
      chk("s4_ack0", 0, int'(ack0_o[0]), int'(c == 3));
    end
    #1; req0 = 1'b0;
    drv_wait(6);

    // Reset during lane 2 of a channel-1 word, then a tie after release.
    req1 = 1'b1; data1 = 8'h5A; seen = 0;
    for (int k = 0; k < 16 && seen == 0; k++) begin
      @(negedge clk_4f); #1;
      if (ack1_o[0] && lane_o[0] == 2'd1) seen = 1;
    end
    chk("s5_lane2", 0, seen, 1);
    #1; reset_L = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("s5_data", i, int'(dout_o[i]), 0);
      chk("s5_valid", i, int'(valid_o[i]), 0);
      chk("s5_ack1", i, int'(ack1_o[i]), 0);
    end
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22;
    drv_wait(2);
    reset_L = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_4f); #1;
      for (int i = 0; i < 2; i++) begin
        chk("s5_tie_ack0", i, int'(ack0_o[i]), int'(c == 4));
        chk("s5_tie_ack1", i, int'(ack1_o[i]), 0);
      end
    end
    #1;
    drv_wait(16);

    // Randomised requests and data.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) req0 = ~req0;
      if ($urandom_range(0, 7) == 0) req1 = ~req1;
      data0 = 8'($urandom);
      data1 = 8'($urandom);
      drv_wait(1);
    end
    req0 = 1'b0; req1 = 1'b0;
    drv_wait(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
